// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer. Synchronizes the serial line, times
// each bit with a full/half-bit counter, samples data at mid-bit, checks the
// stop bit and emits each word with a one-cycle rx_valid strobe.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit per frame.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 parity_error,
   output logic                 rx_busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_M1  = TW'(HALF_BIT - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);
   localparam logic          PAR_SENSE = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t               state, state_nxt;
   logic                 sync1, sync2;
   logic                 armed;
   logic [TW-1:0]        tmr;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 data_smp, stop_smp;

   assign rx_busy = (state != S_IDLE);

   // two-flop synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx_serial;
         sync2 <= sync1;
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state and sample strobes; every state leaves on an equality compare
   always_comb begin
      state_nxt = state;
      data_smp  = 1'b0;
      stop_smp  = 1'b0;
      case (state)
         S_IDLE:
            if (armed && !sync2) state_nxt = S_START;
         S_START:
            if (tmr == HALF_M1) state_nxt = sync2 ? S_IDLE : S_DATA;
         S_DATA:
            if (tmr == FULL_M1) begin
               data_smp = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == LAST_IDX) state_nxt = S_PARITY;
`else
               if (bit_idx == LAST_IDX) state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
         S_PARITY:
            if (tmr == FULL_M1) state_nxt = S_STOP;
`endif
         S_STOP:
            if (tmr == FULL_M1) begin
               stop_smp  = 1'b1;
               state_nxt = S_IDLE;
            end
         default: state_nxt = S_IDLE;
      endcase
   end

   // bit timer: restarts on each state entry and after each data sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmr <= '0;
      else if (state == S_IDLE || state_nxt != state || data_smp)
         tmr <= '0;
      else
         tmr <= tmr + 1'b1;
   end

   // arm: a new start edge is only accepted after the line has been seen high
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         armed <= 1'b1;
      else if (state != S_IDLE && state_nxt == S_IDLE)
         armed <= 1'b0;
      else if (state == S_IDLE && sync2)
         armed <= 1'b1;
   end

   // data path: bit counter and LSB-first shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state == S_START && state_nxt == S_DATA)
            bit_idx <= '0;
         else if (data_smp)
            bit_idx <= bit_idx + 1'b1;
         if (data_smp)
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
      end
   end

   // output word and framing flag, updated only with the strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (stop_smp) begin
            rx_data       <= shreg;
            rx_valid      <= 1'b1;
            framing_error <= ~sync2;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   // capture parity bit, then compare against the word at the stop sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_bit      <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         if (state == S_PARITY && tmr == FULL_M1)
            par_bit <= sync2;
         if (stop_smp)
            parity_error <= par_bit ^ (^shreg) ^ PAR_SENSE;
      end
   end
`else
   logic unused_par;
   assign unused_par   = PAR_SENSE;
   assign parity_error = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer: oversamples the asynchronous serial line with an internal bit-period timer, detects the start bit, samples each data bit at mid-bit, checks the stop bit, and presents each received word with a one-cycle valid strobe and error qualifiers. It sits between the serial pin and the receive-side consumer (FIFO or register file). The bit-period timer uses the same full/half-bit counting scheme as the existing receive counter, so parameter values carry over unchanged.

## Interface
- CLKS_PER_BIT, 434, clock cycles per bit period; must be ≥ 2.
- HALF_BIT, 217, cycles from the start-bit falling edge to the start-bit sample point; 1 ≤ HALF_BIT < CLKS_PER_BIT.
- DATA_BITS, 8, data bits per frame; range 5–9; LSB received first.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only under UART_RX_PARITY_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_serial  input  1  raw serial line; idles high; asynchronous to clk.
- rx_data  output  DATA_BITS  last received word; held until the next rx_valid.
- rx_valid  output  1  one-cycle strobe; rx_data and the error flags are updated on the same edge.
- framing_error  output  1  stop bit sampled low; updated only with rx_valid.
- parity_error  output  1  parity mismatch; updated only with rx_valid.
- rx_busy  output  1  high in every state except IDLE.

## Operation
- Input path: 2-flop synchronizer (sync1, sync2), both reset to 1. All decisions use sync2.
- Timer: width ceil(log2(CLKS_PER_BIT)). Cleared on every state entry. Increments every cycle outside IDLE.
- Arm bit: cleared on entry to IDLE. Set when sync2 is high in IDLE. Set at reset.
- IDLE: if armed and sync2 == 0, go to START.
- START: when timer == HALF_BIT-1, sample sync2. If 0, go to DATA with bit_idx = 0. If 1, the low pulse was a glitch: go to IDLE with no strobe and no flag change.
- DATA: when timer == CLKS_PER_BIT-1, shift sync2 into the MSB of the shift register (right shift, LSB-first) and increment bit_idx. After the DATA_BITS-th sample, go to PARITY (macro defined) or STOP.
- PARITY: when timer == CLKS_PER_BIT-1, sample the parity bit and go to STOP.
- STOP: when timer == CLKS_PER_BIT-1, sample the stop bit. On that edge:
  - rx_data <= shift register
  - rx_valid <= 1
  - framing_error <= ~sample
  - parity_error <= mismatch
  - go to IDLE.
- rx_valid falls on the next edge.
- A word is delivered even when it carries errors; the flags qualify it.
- Line held low after a framing error (break): no new frame starts until sync2 returns high, because IDLE is unarmed.
- Reset at any time, including mid-frame: state IDLE, armed, timer/bit_idx/shift register 0, all outputs 0, sync flops 1.

## Timing
- Let E0 be the first clock edge that samples rx_serial low.
  - sync2 goes low after E1.
  - START is entered at E2.
  - The start bit is sampled at E2+HALF_BIT.
  - Data bit k (k = 1..DATA_BITS) is sampled at E2+HALF_BIT+k·CLKS_PER_BIT.
- Stop-bit sample edge:
  - Macro off: E2+HALF_BIT+(DATA_BITS+1)·CLKS_PER_BIT.
  - Macro on: E2+HALF_BIT+(DATA_BITS+2)·CLKS_PER_BIT.
- rx_valid is high for exactly the cycle following the stop-bit sample edge.
- Defaults, macro off: the stop sample is at E0+4125, and rx_valid is high during the cycle after that edge.
- The block returns to IDLE at the stop-bit midpoint, so a start bit that immediately follows the stop bit (zero idle time) is captured.
- Timer arithmetic is unsigned. Compares are equality-only, and no state allows the timer to exceed its compare value.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present; one parity bit between the last data bit and the stop bit.
  - Expected parity = XOR(data) ^ PARITY_ODD.
  - parity_error = received ≠ expected.
- Not defined:
  - No PARITY state and no parity logic.
  - Frame is start + DATA_BITS + stop.
  - parity_error is tied to 0; PARITY_ODD is ignored.

## Test plan
- 8N1, defaults, 0xA5 sent at 434 cycles/bit -> one rx_valid pulse at E0+4125, rx_data = 0xA5, framing_error = 0, rx_busy low afterwards.
- 100-cycle low glitch on an idle line -> START aborts at the half-bit sample, no rx_valid, rx_data unchanged, rx_busy high for ≤ 219 cycles.
- 0x3C with the stop bit driven low, then line held low for 5000 cycles -> rx_valid, rx_data = 0x3C, framing_error = 1; no further frame until the line returns high; a subsequent 0x11 is received cleanly with framing_error = 0.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two rx_valid pulses exactly 4340 cycles apart, data correct, no errors.
- reset pulsed high during data bit 4, then a clean 0x5A -> all outputs 0 while reset is high, then 0x5A received with no errors.
- UART_RX_PARITY_EN, PARITY_ODD = 0: 0x07 with parity bit 1 -> parity_error = 0; same word with parity bit 0 -> parity_error = 1, rx_data = 0x07.
